// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the sequencer state encoding.
// Also used by the control-unit decoder.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per clock.
// Result is presented combinationally on the cycle done is high.
module seq_alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    logic [WIDTH-1:0] acc_q, b_q, m_q;
    logic [WIDTH-1:0] cur_acc, cur_b, cur_m, nxt_acc, nxt_b;
    logic [WIDTH:0]   sum, shifted, diff;
    logic             div_q, busy_q, cur_div;
    logic [CNT_W-1:0] cnt_q;

    // The accept edge already performs iteration 0 on the raw operands, so the
    // counter holds the index of the iteration the coming edge performs.
    always_comb begin
        cur_acc = start ? '0 : acc_q;
        cur_b   = start ? op_a : b_q;
        cur_m   = start ? op_b : m_q;
        cur_div = start ? is_div : div_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (cur_div) begin
            shifted = {cur_acc, cur_b[WIDTH-1]};
            diff    = shifted - {1'b0, cur_m};
            if (!diff[WIDTH]) begin
                nxt_acc = diff[WIDTH-1:0];
                nxt_b   = {cur_b[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = shifted[WIDTH-1:0];
                nxt_b   = {cur_b[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, cur_acc} + (cur_b[0] ? {1'b0, cur_m} : '0);
            nxt_acc = sum[WIDTH:1];
            nxt_b   = {sum[0], cur_b[WIDTH-1:1]};
        end
    end

    assign done   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign res_lo = nxt_b;
    assign res_hi = nxt_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(1);
            m_q    <= op_b;
            div_q  <= is_div;
            acc_q  <= nxt_acc;
            b_q    <= nxt_b;
        end else if (busy_q) begin
            acc_q <= nxt_acc;
            b_q   <= nxt_b;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle ops plus iterative mulu/divu behind a start/ready/valid
// handshake. Define SEQ_ALU_OVF_EN to add the signed-overflow output ovf.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [15:0]      imm16,
    input  logic             ALUsrc,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] hi,
    output logic             zero
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] sext, opnd_b, sum, diff, sc_ans, sc_hi, md_lo, md_hi;
    logic [WIDTH-1:0] ans_q, ans_d, hi_q, hi_d;
    logic [3:0]       op;
    logic             accept, is_mul, is_div, md_start, md_done, valid_q, valid_d;

    assign sext     = WIDTH'($signed(imm16));
    assign op       = ALUsrc ? OP_ADD : ALUctrl;
    assign opnd_b   = ALUsrc ? sext : busB;
    assign sum      = busA + opnd_b;
    assign diff     = busA - opnd_b;
    assign accept   = start && ready;
    assign is_mul   = (op == OP_MULU);
    assign is_div   = (op == OP_DIVU) && (busB != '0);
    assign md_start = accept && (is_mul || is_div);

    always_comb begin
        sc_ans = '0;
        sc_hi  = '0;
        case (op)
            OP_ADD:          sc_ans = sum;
            OP_SUB, OP_BEQ:  sc_ans = diff;
            OP_AND:          sc_ans = busA & busB;
            OP_OR:           sc_ans = busA | busB;
            OP_XOR:          sc_ans = busA ^ busB;
            OP_SLT:          sc_ans = WIDTH'($signed(busA) < $signed(busB));
            OP_SLTU:         sc_ans = WIDTH'(busA < busB);
            // Only reached as a single-cycle op when the divisor is zero.
            OP_DIVU: begin
                sc_ans = '1;
                sc_hi  = busA;
            end
            default: ;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (is_div),
        .op_a   (busA),
        .op_b   (busB),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ans_q   <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ans_q   <= ans_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : (is_div ? DIV : DONE);
                end
            end
            MUL, DIV: begin
                if (md_done) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q == IDLE) || (state_q == DONE);
        ans_d   = ans_q;
        hi_d    = hi_q;
        valid_d = 1'b0;
        if (accept && !md_start) begin
            ans_d   = sc_ans;
            hi_d    = sc_hi;
            valid_d = 1'b1;
        end else if (md_done) begin
            ans_d   = md_lo;
            hi_d    = md_hi;
            valid_d = 1'b1;
        end
    end

    assign valid = valid_q;
    assign ans   = ans_q;
    assign hi    = hi_q;
    assign zero  = (ans_q == '0);

`ifdef SEQ_ALU_OVF_EN
    logic sc_ovf, ovf_q;

    always_comb begin
        sc_ovf = 1'b0;
        if (op == OP_ADD) begin
            sc_ovf = (busA[WIDTH-1] == opnd_b[WIDTH-1]) && (sum[WIDTH-1] != busA[WIDTH-1]);
        end else if (op == OP_SUB || op == OP_BEQ) begin
            sc_ovf = (busA[WIDTH-1] != opnd_b[WIDTH-1]) && (diff[WIDTH-1] != busA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept && !md_start) begin
            ovf_q <= sc_ovf;
        end else if (md_done) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
